// File: rtl/scancode_matrix_mapper_if.sv
// Bus bundle between the PS/2 receiver/host side and the scancode matrix mapper.
// The master side drives scan bytes, keymap writes, row selects and overlays;
// the slave side (the mapper) returns column read-back and status.
interface scancode_matrix_mapper_if #(
    parameter int NROWS = 9,
    parameter int NCOLS = 8
);
    logic                   scan_valid;
    logic [7:0]             scan;
    logic                   clr;
    logic                   map_we;
    logic [8:0]             map_addr;
    logic [7:0]             map_data;
    logic                   map_ready;
    logic [NROWS-1:0]       key_row;
    logic [NCOLS-1:0]       key_col;
    logic [NROWS*NCOLS-1:0] ovl;
    logic [7:0]             func;
    logic                   pause_pulse;
    logic                   any_key;

    modport master (
        output scan_valid, scan, clr, map_we, map_addr, map_data, key_row, ovl,
        input  map_ready, key_col, func, pause_pulse, any_key
    );

    modport slave (
        input  scan_valid, scan, clr, map_we, map_addr, map_data, key_row, ovl,
        output map_ready, key_col, func, pause_pulse, any_key
    );
endinterface

// File: rtl/scancode_matrix_mapper.sv
// PS/2 set-2 scancode to keyboard-matrix mapper with a run-time loadable
// 512-entry keymap ({ext, code} -> {valid, row, col}).
//
// Init FSM
//   state  | meaning
//   S_INIT | clearing keymap, one address per clk; scan bytes and host writes ignored
//   S_RUN  | keymap ready, decoding active
//
// Decode FSM
//   state  | meaning
//   S_IDLE | no prefix pending (ext = rel = 0)
//   S_PFX  | E0 and/or F0 seen, waiting for the code byte (timer running)
//   S_SKIP | swallowing the remainder of the E1 Pause sequence (timer running)
module scancode_matrix_mapper #(
    parameter int NROWS   = 9,
    parameter int NCOLS   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scancode_matrix_mapper_if.slave bus
);
    localparam int NBITS = NROWS * NCOLS;
    localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Loaded one below TIMEOUT so the prefix expires TIMEOUT cycles after its last byte.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_FE = 8'hFE;

    typedef enum logic {
        S_INIT,
        S_RUN
    } init_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PFX,
        S_SKIP
    } dec_state_t;

    init_state_t      init_state_q, init_state_d;
    logic [8:0]       init_addr_q, init_addr_d;
    logic             run;

    dec_state_t       dec_state_q, dec_state_d;
    logic             ext_q, ext_d;
    logic             rel_q, rel_d;
    logic [2:0]       skip_q, skip_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             pause_q, pause_d;

    logic             byte_v;
    logic             is_ack;
    logic             lk_req;
    logic [8:0]       lk_addr;
    logic             aa_clr;
    logic             clr_all;

    logic [7:0]       mem_q [0:511];
    logic             mem_we;
    logic [8:0]       mem_waddr;
    logic [7:0]       mem_wdata;
    logic [7:0]       rd_data_q;
    logic             lk_valid_q;
    logic             lk_rel_q;

    logic             ent_valid;
    logic [3:0]       ent_row;
    logic [2:0]       ent_col;
    logic             press;

    logic [NBITS-1:0] mat_q, mat_d;
    logic [7:0]       func_q, func_d;
    logic [NCOLS-1:0] col_acc;

    assign run     = (init_state_q == S_RUN);
    assign byte_v  = run & bus.scan_valid;
    assign is_ack  = (bus.scan == SC_FA) || (bus.scan == SC_EE) || (bus.scan == SC_FE);
    assign lk_addr = {ext_q, bus.scan};
    assign clr_all = bus.clr | aa_clr;

    // Init FSM register: walk the clear address and hand over to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_state_q <= S_INIT;
            init_addr_q  <= '0;
        end else begin
            init_state_q <= init_state_d;
            init_addr_q  <= init_addr_d;
        end
    end

    // Init FSM next state: clear all 512 entries, then stay in RUN.
    always_comb begin
        init_state_d = init_state_q;
        init_addr_d  = init_addr_q;
        case (init_state_q)
            S_INIT: begin
                init_addr_d = init_addr_q + 9'd1;
                if (init_addr_q == 9'd511) begin
                    init_state_d = S_RUN;
                end
            end
            S_RUN:   init_state_d = S_RUN;
            default: init_state_d = S_INIT;
        endcase
    end

    // During INIT the clear sequence owns the write port; host writes are dropped.
    assign mem_we    = run ? bus.map_we   : 1'b1;
    assign mem_waddr = run ? bus.map_addr : init_addr_q;
    assign mem_wdata = run ? bus.map_data : 8'h00;

    // Keymap RAM: registered read, read-first against a same-cycle write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        if (lk_req) begin
            rd_data_q <= mem_q[lk_addr];
        end
    end

    // Decode FSM register plus prefix/skip flags, timeout timer and pause pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state_q <= S_IDLE;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= '0;
            tmr_q       <= '0;
            pause_q     <= 1'b0;
        end else begin
            dec_state_q <= dec_state_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            tmr_q       <= tmr_d;
            pause_q     <= pause_d;
        end
    end

    // Decode FSM next state: classify each strobed byte, run the prefix/skip timeout.
    always_comb begin
        dec_state_d = dec_state_q;
        ext_d       = ext_q;
        rel_d       = rel_q;
        skip_d      = skip_q;
        tmr_d       = tmr_q;
        pause_d     = 1'b0;
        lk_req      = 1'b0;
        aa_clr      = 1'b0;
        case (dec_state_q)
            S_IDLE, S_PFX: begin
                if (byte_v) begin
                    // Any byte restarts the timeout window.
                    tmr_d = TMR_LOAD;
                    if (bus.scan == SC_E0) begin
                        ext_d       = 1'b1;
                        dec_state_d = S_PFX;
                    end else if (bus.scan == SC_F0) begin
                        rel_d       = 1'b1;
                        dec_state_d = S_PFX;
                    end else if ((bus.scan == SC_E1) && (dec_state_q == S_IDLE)) begin
                        skip_d      = 3'd7;
                        dec_state_d = S_SKIP;
                    end else if ((bus.scan == SC_AA) && (dec_state_q == S_IDLE)) begin
                        aa_clr = 1'b1;
                    end else if (is_ack) begin
                        // Keyboard acknowledge/echo/resend: no effect on decode.
                    end else begin
                        lk_req      = 1'b1;
                        ext_d       = 1'b0;
                        rel_d       = 1'b0;
                        dec_state_d = S_IDLE;
                    end
                end else if (dec_state_q == S_PFX) begin
                    if (tmr_q == '0) begin
                        ext_d       = 1'b0;
                        rel_d       = 1'b0;
                        dec_state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
            end
            S_SKIP: begin
                if (byte_v) begin
                    tmr_d = TMR_LOAD;
                    if (skip_q == 3'd1) begin
                        skip_d      = '0;
                        pause_d     = 1'b1;
                        dec_state_d = S_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end else if (tmr_q == '0) begin
                    // Truncated Pause sequence: give up silently.
                    skip_d      = '0;
                    dec_state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                dec_state_d = S_IDLE;
                ext_d       = 1'b0;
                rel_d       = 1'b0;
                skip_d      = '0;
            end
        endcase
    end

    // Lookup pipeline: remembers that a RAM read is in flight and its make/break sense.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_valid_q <= 1'b0;
            lk_rel_q   <= 1'b0;
        end else begin
            lk_valid_q <= lk_req;
            if (lk_req) begin
                lk_rel_q <= rel_q;
            end
        end
    end

    assign ent_valid = rd_data_q[7];
    assign ent_row   = rd_data_q[6:3];
    assign ent_col   = rd_data_q[2:0];
    assign press     = ~lk_rel_q;

    // Apply the looked-up entry to matrix/func; a clear in the same cycle wins.
    always_comb begin
        mat_d  = mat_q;
        func_d = func_q;
        if (lk_valid_q && ent_valid) begin
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    if ((ent_row == 4'(r)) && (ent_col == 3'(c))) begin
                        mat_d[r*NCOLS + c] = press;
                    end
                end
            end
            if (ent_row == 4'hF) begin
                func_d[ent_col] = press;
            end
        end
        if (clr_all) begin
            mat_d  = '0;
            func_d = '0;
        end
    end

    // Matrix and function-key level state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q  <= '0;
            func_q <= '0;
        end else begin
            mat_q  <= mat_d;
            func_q <= func_d;
        end
    end

    // Column read-back: OR of all selected (low) rows, including overlay presses.
    always_comb begin
        col_acc = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (!bus.key_row[r]) begin
                col_acc = col_acc | mat_q[r*NCOLS +: NCOLS] | bus.ovl[r*NCOLS +: NCOLS];
            end
        end
    end

    assign bus.key_col     = ~col_acc;
    assign bus.func        = func_q;
    assign bus.pause_pulse = pause_q;
    assign bus.any_key     = (|mat_q) | (|func_q);
    assign bus.map_ready   = run;
endmodule
